// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Command/status bundle for countdown_timer.
//                master : drives en, load, load_val, start, pause, auto_reload
//                         and observes count, running, done, zero.
//                slave  : the timer itself (mirror image of master).
//  Ports       : none (signal bundle only); WIDTH sets load_val/count width.
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             zero;

  modport master (
    output en, load, load_val, start, pause, auto_reload,
    input  count, running, done, zero
  );

  modport slave (
    input  en, load, load_val, start, pause, auto_reload,
    output count, running, done, zero
  );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with one-shot / periodic modes,
//                pause/resume and a one-cycle terminal-count pulse.
//                Optional en prescaler compiled in with macro
//                COUNTDOWN_PRESCALER_EN (default build: every en pulse
//                is a decrement step).
//  Ports       : clk    - single clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - countdown_timer_if.slave
//                         in : en, load, load_val, start, pause, auto_reload
//                         out: count, running, done (registered),
//                              zero (combinational count == 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT   = '1,
  parameter int             PRESCALE = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  countdown_timer_if.slave bus
);

  // Out-of-range parameters stop elaboration rather than build a broken timer.
  if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_params
    $error("countdown_timer: WIDTH or PRESCALE out of range");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             running_q;
  logic             done_q;
  logic             step;

`ifdef COUNTDOWN_PRESCALER_EN
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;

  // A step is the en pulse that completes a full prescale period.
  assign step = bus.en && (presc_q == PMAX);
`else
  assign step = bus.en;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= INIT;
      reload_q  <= INIT;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTDOWN_PRESCALER_EN
      presc_q   <= '0;
`endif
    end else begin
      // done is a single-cycle pulse unless re-armed below.
      done_q <= 1'b0;

      if (bus.load) begin
        // load overrides everything, including a coincident terminal step.
        count_q   <= bus.load_val;
        reload_q  <= bus.load_val;
        state_q   <= S_IDLE;
        running_q <= 1'b0;
`ifdef COUNTDOWN_PRESCALER_EN
        presc_q   <= '0;
`endif
      end else if (bus.pause) begin
        // pause outranks start; it only has an effect while running.
        if (state_q == S_RUN) begin
          state_q   <= S_PAUSE;
          running_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start && (count_q != '0)) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
`ifdef COUNTDOWN_PRESCALER_EN
              presc_q   <= '0;
`endif
            end
          end

          S_PAUSE: begin
            // Resume keeps the prescaler phase where it was paused.
            if (bus.start && (count_q != '0)) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end

          S_DONE: begin
            if (bus.start && (reload_q != '0)) begin
              count_q   <= reload_q;
              state_q   <= S_RUN;
              running_q <= 1'b1;
`ifdef COUNTDOWN_PRESCALER_EN
              presc_q   <= '0;
`endif
            end
          end

          S_RUN: begin
`ifdef COUNTDOWN_PRESCALER_EN
            if (bus.en) begin
              presc_q <= (presc_q == PMAX) ? '0 : presc_q + PW'(1);
            end
`endif
            if (step) begin
              if (count_q > ONE) begin
                count_q <= count_q - ONE;
              end else if (count_q == ONE) begin
                // Terminal count: mode is sampled only here.
                done_q <= 1'b1;
                if (bus.auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  count_q   <= '0;
                  state_q   <= S_DONE;
                  running_q <= 1'b0;
                end
              end
              // count_q == 0 in RUN cannot be reached; hold rather than wrap.
            end
          end

          default: begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.zero    = (count_q == '0);

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 SHALL have parameter INIT, default all ones (2**WIDTH-1), reset value of count and reload register.
REQ-003 SHALL have parameter PRESCALE, default 4, en pulses per decrement when the prescaler is compiled in; legal range 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  count-enable strobe.
REQ-007 SHALL have port load  input  1  load load_val into count and the reload register.
REQ-008 SHALL have port load_val  input  WIDTH  value captured on load.
REQ-009 SHALL have port start  input  1  start or resume counting.
REQ-010 SHALL have port pause  input  1  suspend counting.
REQ-011 SHALL have port auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
REQ-012 SHALL have port count  output  WIDTH  current count, registered.
REQ-013 SHALL have port running  output  1  high in state RUN, registered.
REQ-014 SHALL have port done  output  1  one-cycle terminal-count pulse, registered.
REQ-015 SHALL have port zero  output  1  combinational (count == 0).

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 SHALL apply command priority rst_n low > load > pause > start on each edge.
REQ-018 On load, in any state: count <= load_val; reload_reg <= load_val; state <= IDLE; prescaler cleared.
REQ-019 On start in IDLE or PAUSE with count != 0: state <= RUN; start with count == 0 is ignored.
REQ-020 On start in DONE with reload_reg != 0: count <= reload_reg; state <= RUN; otherwise the command is ignored.
REQ-021 On pause in RUN: state <= PAUSE; count and prescaler hold; pause is ignored in other states.
REQ-022 Define step as the decrement qualifier, evaluated only in RUN (see REQ-031/032).
REQ-023 On step in RUN with count > 1: count <= count - 1.
REQ-024 On step in RUN with count == 1 and auto_reload == 1: count <= reload_reg; done pulses; state stays RUN.
REQ-025 On step in RUN with count == 1 and auto_reload == 0: count <= 0; done pulses; state <= DONE.
REQ-026 count SHALL never wrap below 0; no decrement occurs outside RUN.
REQ-027 done SHALL be asserted for exactly the one cycle after the terminal-count edge; it is never asserted in back-to-back cycles unless reload_reg == 1 with step every cycle.
REQ-028 load and a terminal-count step in the same cycle: load wins and done stays 0.
REQ-029 auto_reload is sampled only at terminal count and may change at any time.

Reset
REQ-030 When rst_n is low at a clock edge: count <= INIT; reload_reg <= INIT; state <= IDLE; running <= 0; done <= 0; prescaler <= 0; reset mid-count discards all progress.

Configuration
REQ-031 With macro COUNTDOWN_PRESCALER_EN defined: an internal prescaler counts en pulses in RUN; step = en && prescaler == PRESCALE-1, after which the prescaler returns to 0; the prescaler holds in PAUSE and clears on load, on reset, and on entry to RUN from IDLE or DONE.
REQ-032 Without COUNTDOWN_PRESCALER_EN: step = en; PRESCALE is ignored and no prescaler register exists.

Verification
REQ-033 Reset: WIDTH=8, rst_n=0 for 1 edge -> count=255, running=0, done=0, zero=0.
REQ-034 One-shot: load_val=3, load, start, en=1 continuously, no prescaler -> count 3,2,1,0 on successive edges; done high 1 cycle with count=0; state DONE; running=0.
REQ-035 Periodic: load_val=2, auto_reload=1, start, en=1 -> count 2,1,2,1,...; done pulses every 2nd cycle; running stays 1.
REQ-036 Pause/resume: count=5 in RUN, pause for 3 cycles with en=1 -> count holds 5; start -> decrement resumes to 4 next step.
REQ-037 Priority: load=1, pause=1, start=1 in the same cycle with load_val=7 -> count=7, state IDLE, done=0; start with count=0 -> stays IDLE.
REQ-038 Prescaler (macro defined, PRESCALE=4): load 2, start, en=1 -> count decrements on every 4th edge; reaches 0 after 8 en pulses; rst_n=0 midway -> count=INIT, prescaler=0.
